// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation modes
// and a classifier for the operations that advance the frame counter.
package shift_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        SHR   = 3'd1,
        SHL   = 3'd2,
        ASR   = 3'd3,
        ROR   = 3'd4,
        ROL   = 3'd5,
        LOAD  = 3'd6,
        CLEAR = 3'd7
    } shift_mode_e;

    // True for the five operations that move bits and count toward a frame.
    function automatic logic is_shift(input shift_mode_e mode);
        return (mode == SHR) || (mode == SHL) || (mode == ASR) ||
               (mode == ROR) || (mode == ROL);
    endfunction

    // True for the operations that start a new frame from zero.
    function automatic logic is_restart(input shift_mode_e mode);
        return (mode == LOAD) || (mode == CLEAR);
    endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// Counts accepted shifts modulo WIDTH and pulses done for one cycle each
// time a full frame of WIDTH shifts has been completed.
module shift_frame_counter #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inc,
    input  logic                       clr,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Frame count and completion pulse; done is high only in the cycle after a wrap.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and sampled like any other input, so it
        // sits inside the clocked branch and takes priority over inc/clr.
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (inc) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                done <= 1'b1;
            end else begin
                cnt  <= cnt + CW'(1);
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: shift/rotate in both directions, arithmetic
// right shift, parallel load and clear, with a frame counter that tracks
// shifts since the last load or clear.
module universal_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  shift_mode_e                mode,
    input  logic                       sin_r,
    input  logic                       sin_l,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           q,
    output logic                       sout_r,
    output logic                       sout_l,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       done
);

    logic inc;
    logic clr;

    assign inc    = en & is_shift(mode);
    assign clr    = en & is_restart(mode);
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    // Data path: one register updated by the selected operation when enabled.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every right-hand side reads the
        // pre-edge value of q, which the shift expressions depend on.
        if (rst) begin
            q <= '0;
        end else if (en) begin
            case (mode)
                SHR:     q <= {sin_r, q[WIDTH-1:1]};
                SHL:     q <= {q[WIDTH-2:0], sin_l};
                ASR:     q <= {q[WIDTH-1], q[WIDTH-1:1]};
                ROR:     q <= {q[0], q[WIDTH-1:1]};
                ROL:     q <= {q[WIDTH-2:0], q[WIDTH-1]};
                LOAD:    q <= d;
                CLEAR:   q <= '0;
                default: q <= q;
            endcase
        end
    end

    shift_frame_counter #(
        .WIDTH (WIDTH)
    ) u_frame (
        .clk  (clk),
        .rst  (rst),
        .inc  (inc),
        .clr  (clr),
        .cnt  (cnt),
        .done (done)
    );

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed-vector bench for universal_shift_register at WIDTH=8.
module tb_universal_shift_register;
    import shift_pkg::*;

    localparam int WIDTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    shift_mode_e       mode;
    logic              sin_r;
    logic              sin_l;
    logic [WIDTH-1:0]  d;
    logic [WIDTH-1:0]  q;
    logic              sout_r;
    logic              sout_l;
    logic [3:0]        cnt;
    logic              done;

    int passed = 0;
    int total  = 0;

    universal_shift_register #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .d      (d),
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .cnt    (cnt),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Apply one operation, clock it, then sample 1 time unit after the edge.
    task automatic step(input logic e, input shift_mode_e m, input logic [7:0] dv,
                        input logic sr, input logic sl);
        en = e; mode = m; d = dv; sin_r = sr; sin_l = sl;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [7:0] eq,
                                input logic [3:0] ec, input logic ed);
        check({tag, ".q"},    q,    eq);
        check({tag, ".cnt"},  cnt,  ec);
        check({tag, ".done"}, done, ed);
    endtask

    // Expected q after each of the five SHR shifts in the en-gap scenario.
    logic [7:0] gap_q [5] = '{8'h09, 8'h04, 8'h02, 8'h01, 8'h00};
    // Expected q after each of the four post-reset SHR shifts with sin_r=1.
    logic [7:0] rst_q [4] = '{8'h80, 8'hC0, 8'hE0, 8'hF0};

    initial begin
        rst = 1'b1; en = 1'b1; mode = LOAD; d = 8'hFF; sin_r = 1'b1; sin_l = 1'b1;
        @(posedge clk); #1;
        expect_state("reset", 8'h00, 4'd0, 1'b0);
        rst = 1'b0;

        // Load then right shift with serial-in 1.
        step(1'b1, LOAD, 8'hA5, 1'b0, 1'b0);
        expect_state("load_a5", 8'hA5, 4'd0, 1'b0);
        step(1'b1, SHR, 8'h00, 1'b1, 1'b0);
        expect_state("shr_a5", 8'hD2, 4'd1, 1'b0);
        check("shr_a5.sout_r", sout_r, 1'b0);
        check("shr_a5.sout_l", sout_l, 1'b1);

        // Arithmetic right shift keeps the sign bit.
        step(1'b1, LOAD, 8'h80, 1'b0, 1'b0);
        step(1'b1, ASR,  8'h00, 1'b0, 1'b0);
        expect_state("asr1", 8'hC0, 4'd1, 1'b0);
        step(1'b1, ASR,  8'h00, 1'b0, 1'b0);
        expect_state("asr2", 8'hE0, 4'd2, 1'b0);

        // Rotations in both directions.
        step(1'b1, LOAD, 8'h81, 1'b0, 1'b0);
        step(1'b1, ROL,  8'h00, 1'b0, 1'b0);
        expect_state("rol", 8'h03, 4'd1, 1'b0);
        step(1'b1, ROR,  8'h00, 1'b0, 1'b0);
        expect_state("ror", 8'h81, 4'd2, 1'b0);

        // Full frame of left shifts: wrap to 0 with a single done pulse.
        step(1'b1, LOAD, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, SHL, 8'h00, 1'b0, 1'b1);
            check($sformatf("shl%0d.q", i),    q,    8'hFF >> (8 - i));
            check($sformatf("shl%0d.cnt", i),  cnt,  4'(i % 8));
            check($sformatf("shl%0d.done", i), done, i == 8);
        end
        // LOAD in the cycle after the wrap: loads d, count stays 0, pulse ends.
        step(1'b1, LOAD, 8'h3C, 1'b0, 1'b0);
        expect_state("load_after_wrap", 8'h3C, 4'd0, 1'b0);
        step(1'b1, HOLD, 8'h00, 1'b0, 1'b0);
        expect_state("hold", 8'h3C, 4'd0, 1'b0);
        step(1'b1, CLEAR, 8'h00, 1'b0, 1'b0);
        expect_state("clear", 8'h00, 4'd0, 1'b0);

        // Frame interrupted by two disabled cycles.
        step(1'b1, LOAD, 8'h96, 1'b0, 1'b0);
        step(1'b1, SHR,  8'h00, 1'b0, 1'b0);
        step(1'b1, SHR,  8'h00, 1'b0, 1'b0);
        step(1'b1, SHR,  8'h00, 1'b0, 1'b0);
        expect_state("gap_pre", 8'h12, 4'd3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, SHL, 8'hFF, 1'b1, 1'b1);
            expect_state($sformatf("gap_off%0d", i), 8'h12, 4'd3, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, SHR, 8'h00, 1'b0, 1'b0);
            expect_state($sformatf("gap_shr%0d", i), gap_q[i], 4'((4 + i) % 8), i == 4);
        end
        step(1'b1, HOLD, 8'h00, 1'b0, 1'b0);
        check("gap_post.done", done, 1'b0);

        // Reset mid-frame discards the partial count.
        step(1'b1, LOAD, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, SHR, 8'h00, 1'b0, 1'b0);
        expect_state("rst_pre", 8'h05, 4'd4, 1'b0);
        rst = 1'b1;
        step(1'b1, SHR, 8'h00, 1'b1, 1'b0);
        rst = 1'b0;
        expect_state("rst_mid", 8'h00, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, SHR, 8'h00, 1'b1, 1'b0);
            expect_state($sformatf("rst_shr%0d", i), rst_q[i], 4'(i + 1), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001: Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004: en  input  1  operation enable; low means the register, counter and flags hold.
REQ-005: mode  input  3  operation select, encoded per the shared mode type (REQ-010).
REQ-006: sin_r  input  1  serial input entering at MSB on right shifts.
REQ-007: sin_l  input  1  serial input entering at LSB on left shifts.
REQ-008: d  input  WIDTH  parallel load data.
REQ-009: q (output, WIDTH) is register contents; sout_r (output, 1) = q[0], combinational; sout_l (output, 1) = q[WIDTH-1], combinational; cnt (output, $clog2(WIDTH+1)) is shifts since last load/clear; done (output, 1) is a one-cycle frame-complete pulse.

Function
REQ-010: Mode encodings SHALL be HOLD=0, SHR=1, SHL=2, ASR=3, ROR=4, ROL=5, LOAD=6, CLEAR=7.
REQ-011: With en=1, q SHALL update next edge as follows: SHR {sin_r,q[W-1:1]}; SHL {q[W-2:0],sin_l}; ASR {q[W-1],q[W-1:1]}; ROR {q[0],q[W-1:1]}; ROL {q[W-2:0],q[W-1]}; LOAD d; CLEAR 0; HOLD unchanged.
REQ-012: Latency SHALL be exactly one clock from the sampled en/mode/d/sin to the updated q; sout_r/sout_l follow q combinationally.
REQ-013: SHR, SHL, ASR, ROR and ROL SHALL be "shift ops"; each accepted shift op SHALL increment cnt by 1.
REQ-014: LOAD and CLEAR SHALL set cnt to 0; HOLD SHALL leave cnt unchanged.
REQ-015: When a shift op moves cnt from WIDTH-1 to WIDTH, cnt SHALL wrap to 0 instead and done SHALL be 1 in the following cycle only.
REQ-016: done SHALL be 0 in every cycle not covered by REQ-015, including cycles after a LOAD, CLEAR, HOLD or en=0.
REQ-017: With en=0, q and cnt SHALL hold regardless of mode, and done SHALL be 0 next cycle.
REQ-018: Mixed shift directions SHALL all count toward the same cnt; direction changes mid-frame SHALL NOT reset cnt.
REQ-019: LOAD in the cycle after wrap SHALL load d and keep cnt=0; done from the wrap SHALL still pulse.

Reset
REQ-020: rst=1 SHALL force q=0, cnt=0, done=0 at the next rising edge, overriding en and mode.
REQ-021: Reset mid-frame SHALL discard the partial count; no done pulse SHALL follow.
REQ-022: Outputs SHALL be stable and defined from the first edge with rst=1; no asynchronous reset path.

Structure
REQ-023: The mode enum (shift_mode_e) and its encodings SHALL reside in shared package shift_pkg.
REQ-024: The cnt/done frame logic SHALL be a sub-module shift_frame_counter, parametrised by WIDTH, with inputs clk, rst, inc, clr and outputs cnt, done.
REQ-025: The data path SHALL be one registered always_ff block with a case on mode; no latches and no generated per-bit flip-flop instances.

Verification (WIDTH=8)
REQ-026: LOAD d=0xA5, then SHR with sin_r=1 -> q=0xA5, then q=0xD2, sout_r=0, cnt=1.
REQ-027: LOAD 0x80, ASR x2 -> q=0xC0, then 0xE0; LOAD 0x81, ROL -> q=0x03; ROR on 0x03 -> 0x81.
REQ-028: LOAD 0x00, 8 consecutive SHL with sin_l=1 -> q=0xFF, cnt=0, done=1 in the cycle after the 8th shift only.
REQ-029: LOAD, 3 SHR, en=0 for 2 cycles (mode=SHL), then 5 SHR -> q frozen while en=0, done pulses once after the 8th shift.
REQ-030: LOAD 0x5A, 4 SHR, rst=1 for one cycle -> q=0, cnt=0; then 4 more shifts -> no done pulse.
